decode_stage: RTL and testbench



---
 rtl/decode_stage_pkg.sv | 97 +++++++++
 rtl/decode_stage_imm_gen.sv | 26 ++
 rtl/decode_stage.sv | 177 +++++++++++++++++
 tb/tb_decode_stage.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, funct3 values, the 4-bit ALU
// operation encoding and immediate format selection. Execute imports this too.
package decode_stage_pkg;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 for BRANCH
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct3 for LOAD / STORE / JALR
    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    // funct7 values that select the alternate OP forms
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU operation class handed to execute
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_NE   = 4'd11,
        ALU_GE   = 4'd12,
        ALU_GEU  = 4'd13,
        ALU_LT   = 4'd14,
        ALU_LTU  = 4'd15
    } alu_op_e;

    // Immediate layout families; FMT_R means no immediate (zero)
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    // FENCE and SYSTEM carry their payload (fm/pred/succ, ECALL/EBREAK) in
    // the I-format field, so execute can tell them apart from imm.
    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_FENCE, OPC_SYSTEM:           fmt = FMT_I;
            OPC_STORE:                       fmt = FMT_S;
            OPC_BRANCH:                      fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:              fmt = FMT_U;
            OPC_JAL:                         fmt = FMT_J;
            default:                         fmt = FMT_R;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: selects the RV32I layout from the
// opcode and sign-extends from instr[31]. Shift-immediates fall out of the
// I layout with shamt in imm[4:0].
module decode_stage_imm_gen
    import decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    // Reassemble the immediate bits for the layout chosen by the opcode.
    always_comb begin
        imm = '0;
        case (imm_fmt(instr[6:0]))
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage. Decodes the fetch beat combinationally and
// registers the result in a single output stage.
//
// Handshake: d_i_ce marks a valid fetch beat. A beat is consumed only on an
// edge where d_i_ce=1, d_i_stall=0 and d_i_flush=0; otherwise fetch keeps
// holding it (stall) or it is dropped (flush). d_o_ce marks a valid decoded
// beat for exactly the cycle after a consuming edge. d_o_stall / d_o_flush
// are the registered stall/flush seen one edge earlier, returned to fetch.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int IWIDTH     = 32,
    parameter int PC_WIDTH   = 32,
    parameter int REG_AWIDTH = 5
) (
    input  logic                  d_clk,
    input  logic                  d_rst,
    input  logic [IWIDTH-1:0]     d_i_instr,
    input  logic [PC_WIDTH-1:0]   d_i_addr_instr,
    input  logic                  d_i_ce,
    input  logic                  d_i_stall,
    input  logic                  d_i_flush,
    output logic [PC_WIDTH-1:0]   d_o_addr_instr,
    output logic [REG_AWIDTH-1:0] d_o_rs1_addr,
    output logic [REG_AWIDTH-1:0] d_o_rs2_addr,
    output logic [REG_AWIDTH-1:0] d_o_rd_addr,
    output logic [31:0]           d_o_imm,
    output logic [6:0]            d_o_opcode,
    output logic [2:0]            d_o_funct3,
    output logic [3:0]            d_o_alu_op,
    output logic                  d_o_exception,
    output logic                  d_o_ce,
    output logic                  d_o_stall,
    output logic                  d_o_flush
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  legal;
    alu_op_e               alu_raw;
    logic [31:0]           imm_raw;
    logic                  capture;

    logic [REG_AWIDTH-1:0] dec_rs1;
    logic [REG_AWIDTH-1:0] dec_rs2;
    logic [REG_AWIDTH-1:0] dec_rd;
    logic [31:0]           dec_imm;
    alu_op_e               dec_alu;

    assign opcode  = d_i_instr[6:0];
    assign funct3  = d_i_instr[14:12];
    assign funct7  = d_i_instr[31:25];
    assign capture = d_i_ce && !d_i_stall && !d_i_flush;

    decode_stage_imm_gen u_imm_gen (
        .instr (d_i_instr),
        .imm   (imm_raw)
    );

    // Legality check and ALU class selection from opcode/funct3/funct7.
    always_comb begin
        legal   = 1'b0;
        alu_raw = ALU_ADD;
        if (d_i_instr[1:0] == 2'b11) begin
            case (opcode)
                OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
                OPC_FENCE, OPC_SYSTEM:       legal = 1'b1;
                OPC_JALR:  legal = (funct3 == F3_JALR);
                OPC_LOAD:  legal = (funct3 == F3_LB)  || (funct3 == F3_LH) ||
                                   (funct3 == F3_LW)  || (funct3 == F3_LBU) ||
                                   (funct3 == F3_LHU);
                OPC_STORE: legal = (funct3 == F3_SB) || (funct3 == F3_SH) ||
                                   (funct3 == F3_SW);
                OPC_BRANCH: begin
                    legal = 1'b1;
                    case (funct3)
                        F3_BEQ:  alu_raw = ALU_EQ;
                        F3_BNE:  alu_raw = ALU_NE;
                        F3_BLT:  alu_raw = ALU_LT;
                        F3_BGE:  alu_raw = ALU_GE;
                        F3_BLTU: alu_raw = ALU_LTU;
                        F3_BGEU: alu_raw = ALU_GEU;
                        default: legal   = 1'b0;
                    endcase
                end
                OPC_OP_IMM: begin
                    legal = 1'b1;
                    case (funct3)
                        F3_ADD_SUB: alu_raw = ALU_ADD;
                        F3_SLL: begin
                            alu_raw = ALU_SLL;
                            legal   = (funct7 == F7_BASE);
                        end
                        F3_SLT:     alu_raw = ALU_SLT;
                        F3_SLTU:    alu_raw = ALU_SLTU;
                        F3_XOR:     alu_raw = ALU_XOR;
                        F3_SRL_SRA: begin
                            alu_raw = funct7[5] ? ALU_SRA : ALU_SRL;
                            legal   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        end
                        F3_OR:      alu_raw = ALU_OR;
                        default:    alu_raw = ALU_AND;
                    endcase
                end
                OPC_OP: begin
                    // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
                    legal = (funct7 == F7_BASE) ||
                            ((funct7 == F7_ALT) &&
                             ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)));
                    case (funct3)
                        F3_ADD_SUB: alu_raw = funct7[5] ? ALU_SUB : ALU_ADD;
                        F3_SLL:     alu_raw = ALU_SLL;
                        F3_SLT:     alu_raw = ALU_SLT;
                        F3_SLTU:    alu_raw = ALU_SLTU;
                        F3_XOR:     alu_raw = ALU_XOR;
                        F3_SRL_SRA: alu_raw = funct7[5] ? ALU_SRA : ALU_SRL;
                        F3_OR:      alu_raw = ALU_OR;
                        default:    alu_raw = ALU_AND;
                    endcase
                end
                default: legal = 1'b0;
            endcase
        end
    end

    // Illegal encodings present zeroed operands and a neutral ADD class.
    always_comb begin
        dec_rs1 = '0;
        dec_rs2 = '0;
        dec_rd  = '0;
        dec_imm = '0;
        dec_alu = ALU_ADD;
        if (legal) begin
            dec_rs1 = d_i_instr[19:15];
            dec_rs2 = d_i_instr[24:20];
            dec_rd  = d_i_instr[11:7];
            dec_imm = imm_raw;
            dec_alu = alu_raw;
        end
    end

    // Output register: data loads only on capture; control follows the
    // previous edge's stall/flush so nothing reaches fetch combinationally.
    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            d_o_addr_instr <= '0;
            d_o_rs1_addr   <= '0;
            d_o_rs2_addr   <= '0;
            d_o_rd_addr    <= '0;
            d_o_imm        <= '0;
            d_o_opcode     <= '0;
            d_o_funct3     <= '0;
            d_o_alu_op     <= '0;
            d_o_exception  <= 1'b0;
            d_o_ce         <= 1'b0;
            d_o_stall      <= 1'b0;
            d_o_flush      <= 1'b0;
        end else begin
            d_o_ce    <= capture;
            d_o_flush <= d_i_flush;
            d_o_stall <= d_i_flush || d_i_stall;
            if (capture) begin
                d_o_addr_instr <= d_i_addr_instr;
                d_o_rs1_addr   <= dec_rs1;
                d_o_rs2_addr   <= dec_rs2;
                d_o_rd_addr    <= dec_rd;
                d_o_imm        <= dec_imm;
                d_o_opcode     <= opcode;
                d_o_funct3     <= funct3;
                d_o_alu_op     <= dec_alu;
                d_o_exception  <= !legal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed vector table, stall/flush/reset
// sequences, then randomized traffic against an instruction-table model.
module tb_decode_stage;
    import decode_stage_pkg::*;

    // ---------------- clock / reset ----------------
    logic        d_clk = 1'b0;
    logic        d_rst;
    logic [31:0] d_i_instr;
    logic [31:0] d_i_addr_instr;
    logic        d_i_ce;
    logic        d_i_stall;
    logic        d_i_flush;
    logic [31:0] d_o_addr_instr;
    logic [4:0]  d_o_rs1_addr;
    logic [4:0]  d_o_rs2_addr;
    logic [4:0]  d_o_rd_addr;
    logic [31:0] d_o_imm;
    logic [6:0]  d_o_opcode;
    logic [2:0]  d_o_funct3;
    logic [3:0]  d_o_alu_op;
    logic        d_o_exception;
    logic        d_o_ce;
    logic        d_o_stall;
    logic        d_o_flush;

    always #5 d_clk = ~d_clk;

    decode_stage dut (
        .d_clk          (d_clk),
        .d_rst          (d_rst),
        .d_i_instr      (d_i_instr),
        .d_i_addr_instr (d_i_addr_instr),
        .d_i_ce         (d_i_ce),
        .d_i_stall      (d_i_stall),
        .d_i_flush      (d_i_flush),
        .d_o_addr_instr (d_o_addr_instr),
        .d_o_rs1_addr   (d_o_rs1_addr),
        .d_o_rs2_addr   (d_o_rs2_addr),
        .d_o_rd_addr    (d_o_rd_addr),
        .d_o_imm        (d_o_imm),
        .d_o_opcode     (d_o_opcode),
        .d_o_funct3     (d_o_funct3),
        .d_o_alu_op     (d_o_alu_op),
        .d_o_exception  (d_o_exception),
        .d_o_ce         (d_o_ce),
        .d_o_stall      (d_o_stall),
        .d_o_flush      (d_o_flush)
    );

    // ---------------- types ----------------
    typedef struct {
        logic [31:0] addr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        exc;
        logic        ce;
        logic        stall;
        logic        flush;
    } outs_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        exc;
    } vec_t;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [2:0]  fmt;
        logic [3:0]  alu;
    } rule_t;

    localparam logic [2:0] K_R = 3'd0, K_I = 3'd1, K_S = 3'd2,
                           K_B = 3'd3, K_U = 3'd4, K_J = 3'd5;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    rule_t rules[$];
    vec_t  vecs[10];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    endtask

    task automatic check_outs(input string tag, input outs_t e);
        check({tag, ".addr"},  d_o_addr_instr,        e.addr);
        check({tag, ".rs1"},   32'(d_o_rs1_addr),     32'(e.rs1));
        check({tag, ".rs2"},   32'(d_o_rs2_addr),     32'(e.rs2));
        check({tag, ".rd"},    32'(d_o_rd_addr),      32'(e.rd));
        check({tag, ".imm"},   d_o_imm,               e.imm);
        check({tag, ".op"},    32'(d_o_opcode),       32'(e.op));
        check({tag, ".f3"},    32'(d_o_funct3),       32'(e.f3));
        check({tag, ".alu"},   32'(d_o_alu_op),       32'(e.alu));
        check({tag, ".exc"},   32'(d_o_exception),    32'(e.exc));
        check({tag, ".ce"},    32'(d_o_ce),           32'(e.ce));
        check({tag, ".stall"}, 32'(d_o_stall),        32'(e.stall));
        check({tag, ".flush"}, 32'(d_o_flush),        32'(e.flush));
    endtask

    function automatic outs_t zero_outs();
        outs_t o;
        o.addr = '0; o.rs1 = '0; o.rs2 = '0; o.rd = '0; o.imm = '0;
        o.op = '0; o.f3 = '0; o.alu = '0; o.exc = 1'b0;
        o.ce = 1'b0; o.stall = 1'b0; o.flush = 1'b0;
        return o;
    endfunction

    function automatic outs_t vec_outs(input vec_t v);
        outs_t o;
        o = zero_outs();
        o.addr = v.addr; o.rs1 = v.rs1; o.rs2 = v.rs2; o.rd = v.rd;
        o.imm = v.imm; o.op = v.instr[6:0]; o.f3 = v.f3; o.alu = v.alu;
        o.exc = v.exc; o.ce = 1'b1;
        return o;
    endfunction

    // ---------------- reference model: RV32I match/mask table ----------------
    function automatic void add_rule(input logic [31:0] m, input logic [31:0] v,
                                     input logic [2:0] f, input alu_op_e a);
        rule_t r;
        r.mask = m; r.match = v; r.fmt = f; r.alu = a;
        rules.push_back(r);
    endfunction

    task automatic build_rules();
        add_rule(32'h7F, 32'h37, K_U, ALU_ADD);          // LUI
        add_rule(32'h7F, 32'h17, K_U, ALU_ADD);          // AUIPC
        add_rule(32'h7F, 32'h6F, K_J, ALU_ADD);          // JAL
        add_rule(32'h707F, 32'h67, K_I, ALU_ADD);        // JALR
        add_rule(32'h707F, 32'h0063, K_B, ALU_EQ);
        add_rule(32'h707F, 32'h1063, K_B, ALU_NE);
        add_rule(32'h707F, 32'h4063, K_B, ALU_LT);
        add_rule(32'h707F, 32'h5063, K_B, ALU_GE);
        add_rule(32'h707F, 32'h6063, K_B, ALU_LTU);
        add_rule(32'h707F, 32'h7063, K_B, ALU_GEU);
        add_rule(32'h707F, 32'h0003, K_I, ALU_ADD);      // LB
        add_rule(32'h707F, 32'h1003, K_I, ALU_ADD);      // LH
        add_rule(32'h707F, 32'h2003, K_I, ALU_ADD);      // LW
        add_rule(32'h707F, 32'h4003, K_I, ALU_ADD);      // LBU
        add_rule(32'h707F, 32'h5003, K_I, ALU_ADD);      // LHU
        add_rule(32'h707F, 32'h0023, K_S, ALU_ADD);      // SB
        add_rule(32'h707F, 32'h1023, K_S, ALU_ADD);      // SH
        add_rule(32'h707F, 32'h2023, K_S, ALU_ADD);      // SW
        add_rule(32'h707F, 32'h0013, K_I, ALU_ADD);      // ADDI
        add_rule(32'h707F, 32'h2013, K_I, ALU_SLT);
        add_rule(32'h707F, 32'h3013, K_I, ALU_SLTU);
        add_rule(32'h707F, 32'h4013, K_I, ALU_XOR);
        add_rule(32'h707F, 32'h6013, K_I, ALU_OR);
        add_rule(32'h707F, 32'h7013, K_I, ALU_AND);
        add_rule(32'hFE00707F, 32'h00001013, K_I, ALU_SLL);   // SLLI
        add_rule(32'hFE00707F, 32'h00005013, K_I, ALU_SRL);   // SRLI
        add_rule(32'hFE00707F, 32'h40005013, K_I, ALU_SRA);   // SRAI
        add_rule(32'hFE00707F, 32'h00000033, K_R, ALU_ADD);
        add_rule(32'hFE00707F, 32'h40000033, K_R, ALU_SUB);
        add_rule(32'hFE00707F, 32'h00001033, K_R, ALU_SLL);
        add_rule(32'hFE00707F, 32'h00002033, K_R, ALU_SLT);
        add_rule(32'hFE00707F, 32'h00003033, K_R, ALU_SLTU);
        add_rule(32'hFE00707F, 32'h00004033, K_R, ALU_XOR);
        add_rule(32'hFE00707F, 32'h00005033, K_R, ALU_SRL);
        add_rule(32'hFE00707F, 32'h40005033, K_R, ALU_SRA);
        add_rule(32'hFE00707F, 32'h00006033, K_R, ALU_OR);
        add_rule(32'hFE00707F, 32'h00007033, K_R, ALU_AND);
        add_rule(32'h7F, 32'h0F, K_I, ALU_ADD);          // FENCE
        add_rule(32'h7F, 32'h73, K_I, ALU_ADD);          // SYSTEM
    endtask

    function automatic outs_t ref_decode(input logic [31:0] w, input logic [31:0] a);
        outs_t o;
        int    hit;
        o = zero_outs();
        o.addr = a; o.op = w[6:0]; o.f3 = w[14:12];
        o.alu = ALU_ADD; o.exc = 1'b1; o.ce = 1'b1;
        hit = -1;
        foreach (rules[k]) if ((w & rules[k].mask) == rules[k].match) hit = k;
        if (hit >= 0) begin
            o.exc = 1'b0;
            o.alu = rules[hit].alu;
            o.rs1 = w[19:15]; o.rs2 = w[24:20]; o.rd = w[11:7];
            case (rules[hit].fmt)
                K_I: o.imm = 32'($signed(w) >>> 20);
                K_S: o.imm = {{20{w[31]}}, w[31:25], w[11:7]};
                K_B: o.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
                K_U: o.imm = w & 32'hFFFFF000;
                K_J: o.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
                default: o.imm = 32'h0;
            endcase
        end
        return o;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge d_clk);
        #1;
    endtask

    task automatic drive(input logic ce, input logic st, input logic fl,
                         input logic [31:0] ins, input logic [31:0] adr);
        d_i_ce = ce; d_i_stall = st; d_i_flush = fl;
        d_i_instr = ins; d_i_addr_instr = adr;
    endtask

    // ---------------- test ----------------
    initial begin : main
        outs_t e;
        logic  rce, rst_, rfl;
        logic [31:0] w, a;
        int k;

        build_rules();
        vecs[0] = '{32'h00500093, 32'h100, 5'd0, 5'd5,  5'd1,  32'd5,        3'd0, ALU_ADD, 1'b0};
        vecs[1] = '{32'hFE208CE3, 32'h104, 5'd1, 5'd2,  5'd25, 32'hFFFFFFF8, 3'd0, ALU_EQ,  1'b0};
        vecs[2] = '{32'h123452B7, 32'h108, 5'd8, 5'd3,  5'd5,  32'h12345000, 3'd5, ALU_ADD, 1'b0};
        vecs[3] = '{32'h40208133, 32'h10C, 5'd1, 5'd2,  5'd2,  32'h0,        3'd0, ALU_SUB, 1'b0};
        vecs[4] = '{32'hFFFFFFFF, 32'h110, 5'd0, 5'd0,  5'd0,  32'h0,        3'd7, ALU_ADD, 1'b1};
        vecs[5] = '{32'h0020A423, 32'h114, 5'd1, 5'd2,  5'd8,  32'd8,        3'd2, ALU_ADD, 1'b0};
        vecs[6] = '{32'h4040D193, 32'h118, 5'd1, 5'd4,  5'd3,  32'h404,      3'd5, ALU_SRA, 1'b0};
        vecs[7] = '{32'h010000EF, 32'h11C, 5'd0, 5'd16, 5'd1,  32'd16,       3'd0, ALU_ADD, 1'b0};
        vecs[8] = '{32'h40001033, 32'h120, 5'd0, 5'd0,  5'd0,  32'h0,        3'd1, ALU_ADD, 1'b1};
        vecs[9] = '{32'h00000000, 32'h124, 5'd0, 5'd0,  5'd0,  32'h0,        3'd0, ALU_ADD, 1'b1};

        // reset state
        d_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_outs("reset", zero_outs());
        tick(); tick();
        d_rst = 1'b1;
        tick();
        check_outs("post_reset_idle", zero_outs());

        // back-to-back table vectors, one beat per cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, vecs[i].instr, vecs[i].addr);
            tick();
            check_outs($sformatf("vec%0d", i), vec_outs(vecs[i]));
        end

        // capture then 3-cycle stall with a pending fetch beat
        drive(1'b1, 1'b0, 1'b0, vecs[0].instr, vecs[0].addr);
        tick();
        check_outs("stall_pre", vec_outs(vecs[0]));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, vecs[1].instr, vecs[1].addr);
            tick();
            e = vec_outs(vecs[0]);
            e.ce = 1'b0; e.stall = 1'b1;
            check_outs($sformatf("stall%0d", i), e);
        end
        drive(1'b1, 1'b0, 1'b0, vecs[1].instr, vecs[1].addr);
        tick();
        check_outs("stall_resume", vec_outs(vecs[1]));

        // flush drops the beat; flush/stall back to fetch for one cycle
        drive(1'b1, 1'b0, 1'b1, vecs[2].instr, vecs[2].addr);
        tick();
        e = vec_outs(vecs[1]);
        e.ce = 1'b0; e.flush = 1'b1; e.stall = 1'b1;
        check_outs("flush", e);
        drive(1'b0, 1'b0, 1'b0, vecs[2].instr, vecs[2].addr);
        tick();
        e.flush = 1'b0; e.stall = 1'b0;
        check_outs("flush_after", e);

        // asynchronous reset mid-stream
        drive(1'b1, 1'b0, 1'b0, vecs[3].instr, vecs[3].addr);
        tick();
        check_outs("pre_async_rst", vec_outs(vecs[3]));
        #2;
        d_rst = 1'b0;
        #1;
        check_outs("async_rst", zero_outs());
        tick();
        drive(1'b0, 1'b0, 1'b0, vecs[0].instr, vecs[0].addr);
        d_rst = 1'b1;
        tick();
        check_outs("rst_no_beat", zero_outs());
        drive(1'b1, 1'b0, 1'b0, vecs[0].instr, vecs[0].addr);
        tick();
        check_outs("rst_first_beat", vec_outs(vecs[0]));

        // randomized traffic against the table model
        e = vec_outs(vecs[0]);
        for (int n = 0; n < 400; n++) begin
            rce  = ($urandom_range(99, 0) < 70);
            rst_ = ($urandom_range(99, 0) < 15);
            rfl  = ($urandom_range(99, 0) < 8);
            if ($urandom_range(1, 0) == 1) begin
                k = int'($urandom_range(rules.size() - 1, 0));
                w = rules[k].match | ($urandom & ~rules[k].mask);
            end else begin
                w = $urandom;
            end
            if (w[6:0] == 7'h0F || w[6:0] == 7'h73) w[14:12] = 3'b000;
            a = $urandom & 32'hFFFFFFFC;
            drive(rce, rst_, rfl, w, a);
            if (rfl) begin
                e.ce = 1'b0; e.flush = 1'b1; e.stall = 1'b1;
            end else if (rst_) begin
                e.ce = 1'b0; e.flush = 1'b0; e.stall = 1'b1;
            end else if (rce) begin
                e = ref_decode(w, a);
            end else begin
                e.ce = 1'b0; e.flush = 1'b0; e.stall = 1'b0;
            end
            tick();
            check_outs($sformatf("rand%0d", n), e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
